// File: rtl/dcache_seq_pkg.sv
// Shared definitions for the D-cache write-back / refill sequencer.
//   seq_state_t    : sequencer FSM states
//   SIZE_WORD      : burst beat size code for 32-bit beats
//   WSTRB_ALL      : full-word write strobe
//   line_off_bits(): number of byte-offset bits in a cache line
package dcache_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_WRESP,
        ST_REFILL,
        ST_DONE
    } seq_state_t;

    localparam logic [2:0] SIZE_WORD = 3'd2;
    localparam logic [3:0] WSTRB_ALL = 4'hF;

    // Byte-offset bits of a line made of 'words' 32-bit words.
    function automatic int unsigned line_off_bits(input int unsigned words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/seq_line_buf.sv
// Line buffer for the D-cache sequencer: WORDS x 32-bit words.
//   clk       : clock
//   load      : parallel load of load_line (word 0 in bits [31:0])
//   wr_en     : write wr_data into word[wr_idx] (ignored while load is high)
//   rd_idx    : combinational read index, rd_data = word[rd_idx]
//   line      : whole buffer, word 0 in bits [31:0]
// The buffer has no reset: its contents survive a sequencer reset.
module seq_line_buf #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned IW    = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  load,
    input  logic [32*WORDS-1:0]   load_line,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_idx,
    input  logic [31:0]           wr_data,
    input  logic [IW-1:0]         rd_idx,
    output logic [31:0]           rd_data,
    output logic [32*WORDS-1:0]   line
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem[i] <= load_line[32*i +: 32];
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

    always_comb begin
        line = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            line[32*i +: 32] = mem[i];
        end
    end

endmodule

// File: rtl/dcache_wb_refill_seq.sv
// D-cache miss sequencer: writes back a dirty victim line as one write
// burst, waits for the write response, then refills the missing line as
// one read burst.
//   clk / rstn          : clock, synchronous active-high reset
//   req_*               : miss request from the cache (accepted in IDLE)
//   done / rline / err  : refill-complete pulse, refilled line, sticky error
//   d_r*                : read burst port      d_w* : write burst port
//   d_bvalid / d_bready : write response
//   perf_wb_cnt / perf_refill_cnt : counters, live only when the macro
//                         SEQ_PERF_CNT_EN is defined, otherwise tied to 0
module dcache_wb_refill_seq
    import dcache_seq_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_dirty,
    input  logic [31:0]                 req_victim_addr,
    input  logic [31:0]                 req_miss_addr,
    input  logic [32*WORDS_PER_LINE-1:0] req_wline,
    output logic                        done,
    output logic [32*WORDS_PER_LINE-1:0] rline,
    output logic                        err,
    output logic                        d_rvalid,
    input  logic                        d_rready,
    output logic [31:0]                 d_raddr,
    input  logic [31:0]                 d_rdata,
    input  logic                        d_rlast,
    output logic [2:0]                  d_rsize,
    output logic [7:0]                  d_rlen,
    output logic                        d_wvalid,
    input  logic                        d_wready,
    output logic [31:0]                 d_waddr,
    output logic [31:0]                 d_wdata,
    output logic [3:0]                  d_wstrb,
    output logic                        d_wlast,
    output logic [2:0]                  d_wsize,
    output logic [7:0]                  d_wlen,
    input  logic                        d_bvalid,
    output logic                        d_bready,
    output logic [31:0]                 perf_wb_cnt,
    output logic [31:0]                 perf_refill_cnt
);

    localparam int unsigned OFF = line_off_bits(WORDS_PER_LINE);
    localparam int unsigned IW  = $clog2(WORDS_PER_LINE);
    localparam int unsigned BW  = IW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);
    localparam logic [31:0]   LINE_MASK = ~((32'd1 << OFF) - 32'd1);

    seq_state_t  state;
    logic [BW-1:0] beat;
    logic [31:0] victim_q;
    logic [31:0] miss_q;
    logic [31:0] buf_rd;
    logic        accept;
    logic        r_fire;
    logic        r_in_range;

    assign accept     = (state == ST_IDLE) && req_valid;
    assign r_fire     = (state == ST_REFILL) && d_rready;
    // The extra counter bit marks beats past the end of the line.
    assign r_in_range = ~beat[IW];

    seq_line_buf #(
        .WORDS (WORDS_PER_LINE),
        .IW    (IW)
    ) u_buf (
        .clk       (clk),
        .load      (!rstn && accept),
        .load_line (req_wline),
        .wr_en     (!rstn && r_fire && r_in_range),
        .wr_idx    (beat[IW-1:0]),
        .wr_data   (d_rdata),
        .rd_idx    (beat[IW-1:0]),
        .rd_data   (buf_rd),
        .line      (rline)
    );

    assign d_raddr = miss_q;
    assign d_waddr = victim_q;
    assign d_rsize = SIZE_WORD;
    assign d_wsize = SIZE_WORD;
    assign d_rlen  = 8'(WORDS_PER_LINE - 1);
    assign d_wlen  = 8'(WORDS_PER_LINE - 1);
    assign d_wstrb = WSTRB_ALL;
    assign d_wdata = (state == ST_WB) ? buf_rd : '0;
    assign d_wlast = (state == ST_WB) && (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state     <= ST_IDLE;
            beat      <= '0;
            err       <= 1'b0;
            victim_q  <= '0;
            miss_q    <= '0;
            req_ready <= 1'b1;
            d_wvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            d_bready  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        victim_q  <= req_victim_addr & LINE_MASK;
                        miss_q    <= req_miss_addr & LINE_MASK;
                        beat      <= '0;
                        err       <= 1'b0;
                        req_ready <= 1'b0;
                        if (req_dirty) begin
                            state    <= ST_WB;
                            d_wvalid <= 1'b1;
                        end else begin
                            state    <= ST_REFILL;
                            d_rvalid <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    if (d_wready) begin
                        if (beat == LAST_BEAT) begin
                            beat     <= '0;
                            state    <= ST_WRESP;
                            d_wvalid <= 1'b0;
                            d_bready <= 1'b1;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                ST_WRESP: begin
                    if (d_bvalid) begin
                        state    <= ST_REFILL;
                        d_bready <= 1'b0;
                        d_rvalid <= 1'b1;
                    end
                end
                ST_REFILL: begin
                    if (d_rready) begin
                        if (d_rlast) begin
                            if (beat != LAST_BEAT) err <= 1'b1;
                            state    <= ST_DONE;
                            d_rvalid <= 1'b0;
                            done     <= 1'b1;
                        end else if (r_in_range) begin
                            beat <= beat + BW'(1);
                        end else begin
                            // Overrun beat: data dropped, counter parked.
                            err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] wb_cnt;
    logic [31:0] refill_cnt;

    always_ff @(posedge clk) begin
        if (rstn) begin
            wb_cnt     <= '0;
            refill_cnt <= '0;
        end else begin
            if (state == ST_WRESP && d_bvalid) wb_cnt <= wb_cnt + 32'd1;
            if (state == ST_DONE) refill_cnt <= refill_cnt + 32'd1;
        end
    end

    assign perf_wb_cnt     = wb_cnt;
    assign perf_refill_cnt = refill_cnt;
`else
    assign perf_wb_cnt     = '0;
    assign perf_refill_cnt = '0;
`endif

endmodule
